// File: rtl/uart_tx_sched.sv
// uart_tx_sched: two-requester round-robin scheduler feeding an 8N1 UART
// transmitter. A request is sampled only while the line is idle; the granted
// byte is latched and serialized start bit, LSB-first data, stop bit, each
// bit lasting DIV clocks. All outputs are registered.
module uart_tx_sched #(
  parameter int unsigned DIV = 5208
) (
  input  logic       clk_50m,
  input  logic       rst,
  input  logic       req0,
  input  logic [7:0] data0,
  output logic       ack0,
  input  logic       req1,
  input  logic [7:0] data1,
  output logic       ack1,
  output logic       tx,
  output logic       busy,
  output logic       frame_done
);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  // Last and second-to-last count of a bit period; DIV >= 2 keeps them distinct.
  localparam logic [15:0] BAUD_LAST = 16'(DIV - 1);
  localparam logic [15:0] BAUD_PRE  = 16'(DIV - 2);

  state_t      state;
  logic [15:0] baud_cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  byte_q;
  logic        last1;     // 1 when requester 1 was served most recently
  logic        grant0;
  logic        grant1;
  logic        bit_end;

  // Round-robin arbitration: a lone requester always wins, a tie goes to the
  // side that was not served last.
  always_comb begin
    grant0  = req0 && (!req1 || last1);
    grant1  = req1 && !grant0;
    bit_end = (baud_cnt == BAUD_LAST);
  end

  // Frame sequencer with registered tx/busy/ack/frame_done.
  always_ff @(posedge clk_50m) begin
    // NOTE: non-blocking assignments here so every register samples the
    // pre-edge values; blocking would let later statements see updated state.
    if (rst) begin
      state      <= IDLE;
      baud_cnt   <= '0;
      bit_idx    <= '0;
      byte_q     <= '0;
      last1      <= 1'b1;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      tx         <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      // Pulses default low and are raised only in the cycle they apply to.
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (grant0 || grant1) begin
            state    <= START;
            baud_cnt <= '0;
            bit_idx  <= '0;
            byte_q   <= grant0 ? data0 : data1;
            last1    <= grant1;
            ack0     <= grant0;
            ack1     <= grant1;
            tx       <= 1'b0;
            busy     <= 1'b1;
          end
        end
        START: begin
          if (bit_end) begin
            state    <= DATA;
            baud_cnt <= '0;
            tx       <= byte_q[0];
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        DATA: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              state <= STOP;
              tx    <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= byte_q[bit_idx + 3'd1];
            end
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        STOP: begin
          if (bit_end) begin
            state    <= IDLE;
            baud_cnt <= '0;
            busy     <= 1'b0;
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
            // Registered pulse: raise it one cycle early so it lands on the
            // final stop-bit cycle.
            if (baud_cnt == BAUD_PRE) frame_done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Testbench for uart_tx_sched (DIV=4): directed scenarios plus randomized
// requests, every cycle compared against a frame-offset reference model.
module tb_uart_tx_sched;

  localparam int DIV   = 4;
  localparam int FRAME = 10 * DIV;

  logic       clk_50m = 1'b0;
  logic       rst     = 1'b1;
  logic       req0    = 1'b0;
  logic [7:0] data0   = 8'h00;
  logic       ack0;
  logic       req1    = 1'b0;
  logic [7:0] data1   = 8'h00;
  logic       ack1;
  logic       tx;
  logic       busy;
  logic       frame_done;

  uart_tx_sched #(.DIV(DIV)) dut (
    .clk_50m   (clk_50m),
    .rst       (rst),
    .req0      (req0),
    .data0     (data0),
    .ack0      (ack0),
    .req1      (req1),
    .data1     (data1),
    .ack1      (ack1),
    .tx        (tx),
    .busy      (busy),
    .frame_done(frame_done)
  );

  always #5 clk_50m = ~clk_50m;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h cycle=%0d", tag, got, exp, cyc);
    end
  endtask

  // Reference model: whether a frame is in flight, the offset into it, the
  // byte and side being sent, and the last-served side.
  bit         m_active = 1'b0;
  int         m_k      = 0;
  logic [7:0] m_byte   = 8'h00;
  bit         m_side   = 1'b0;
  bit         m_ptr    = 1'b1;

  function automatic logic [4:0] m_outs();
    logic tx_e;
    if (!m_active) return 5'b00100;
    if (m_k < DIV)          tx_e = 1'b0;
    else if (m_k < 9 * DIV) tx_e = m_byte[(m_k - DIV) / DIV];
    else                    tx_e = 1'b1;
    return {(m_k == 0) && !m_side, (m_k == 0) && m_side, tx_e, 1'b1, m_k == FRAME - 1};
  endfunction

  task automatic model_advance();
    if (rst) begin
      m_active = 1'b0;
      m_ptr    = 1'b1;
    end else if (!m_active) begin
      if (req0 || req1) begin
        m_side   = (req0 && req1) ? !m_ptr : req1;
        m_byte   = m_side ? data1 : data0;
        m_ptr    = m_side;
        m_active = 1'b1;
        m_k      = 0;
      end
    end else begin
      m_k++;
      if (m_k == FRAME) m_active = 1'b0;
    end
  endtask

  // Requester behaviour: 0 = drop on ack, 1 = drop for one cycle, 2 = hold.
  int   mode0 = 0, mode1 = 0;
  bit   reraise0 = 1'b0, reraise1 = 1'b0;
  int   t_ack0 = 0, t_ack1 = 0, t_ack1_prev = 0, t_fd = 0, t_ack_last = -1000;
  int   n_ack0 = 0, n_ack1 = 0, n_fd = 0, alt_viol = 0;
  bit   have_last = 1'b0, last_side = 1'b0;
  logic [7:0] rx_byte = 8'h00;

  task automatic tick();
    int k;
    @(posedge clk_50m);
    model_advance();
    #1;
    cyc++;
    check("outs{ack0,ack1,tx,busy,fd}", {27'd0, ack0, ack1, tx, busy, frame_done}, {27'd0, m_outs()});
    if (reraise0) begin req0 = 1'b1; reraise0 = 1'b0; end
    if (reraise1) begin req1 = 1'b1; reraise1 = 1'b0; end
    if (ack0) begin
      t_ack0 = cyc; t_ack_last = cyc; n_ack0++;
      if (have_last && !last_side) alt_viol++;
      have_last = 1'b1; last_side = 1'b0;
      if (mode0 != 2) req0 = 1'b0;
      if (mode0 == 1) reraise0 = 1'b1;
    end
    if (ack1) begin
      t_ack1_prev = t_ack1; t_ack1 = cyc; t_ack_last = cyc; n_ack1++;
      if (have_last && last_side) alt_viol++;
      have_last = 1'b1; last_side = 1'b1;
      if (mode1 != 2) req1 = 1'b0;
      if (mode1 == 1) reraise1 = 1'b1;
    end
    if (frame_done) begin t_fd = cyc; n_fd++; end
    // Receiver: sample each data bit mid-period relative to the last ack.
    k = cyc - t_ack_last;
    if (k >= DIV && k < 9 * DIV && (k % DIV) == DIV / 2) rx_byte[(k - DIV) / DIV] = tx;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_ack0(input string tag);
    for (int i = 0; i < 60 && !ack0; i++) tick();
    check(tag, ack0, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    logic [7:0] d;

    // Reset state.
    run(3);
    check("reset_tx", tx, 1'b1);
    check("reset_busy", busy, 1'b0);
    check("reset_acks", {ack0, ack1, frame_done}, 3'b000);
    rst = 1'b0;
    run(2);

    // Single request, 0xA5.
    data0 = 8'hA5; req0 = 1'b1;
    run(50);
    check("a5_frame_done_latency", t_fd - t_ack0, 39);
    check("a5_bits", rx_byte, 8'hA5);

    // Tie right after reset: requester 0 first, requester 1 after one idle cycle.
    rst = 1'b1; tick(); rst = 1'b0;
    data0 = 8'h01; data1 = 8'h80; req0 = 1'b1; req1 = 1'b1;
    run(90);
    check("tie_ack_spacing", t_ack1 - t_ack0, 41);
    check("tie_second_byte", rx_byte, 8'h80);

    // Both held, dropping for one cycle per ack: grants must alternate.
    n_ack0 = 0; n_ack1 = 0; alt_viol = 0; have_last = 1'b0;
    mode0 = 1; mode1 = 1; data0 = 8'h5A; data1 = 8'hC3; req0 = 1'b1; req1 = 1'b1;
    run(410);
    mode0 = 0; mode1 = 0; reraise0 = 1'b0; reraise1 = 1'b0; req0 = 1'b0; req1 = 1'b0;
    run(45);
    check("alternation_violations", alt_viol, 0);
    check("alternation_both_served", (n_ack0 >= 4) && (n_ack1 >= 4), 1'b1);

    // Reset at cycle 15 of a frame, then requester 1 alone.
    data0 = 8'h55; req0 = 1'b1;
    wait_ack0("abort_ack0_seen");
    run(14);
    rst = 1'b1; tick(); rst = 1'b0;
    check("abort_tx", tx, 1'b1);
    check("abort_busy", busy, 1'b0);
    n_fd = 0; n_ack1 = 0;
    run(5);
    check("abort_no_frame_done", n_fd, 0);
    d = 8'($urandom); data1 = d; req1 = 1'b1;
    run(50);
    check("after_abort_ack1_count", n_ack1, 1);
    check("after_abort_byte", rx_byte, {24'd0, d});

    // Data change mid-frame must not corrupt the byte on the line.
    data0 = 8'h3C; req0 = 1'b1;
    wait_ack0("datachg_ack0_seen");
    run(12);
    data0 = 8'hFF;
    run(40);
    check("datachg_bits", rx_byte, 8'h3C);

    // Requester 1 never drops: one ack per frame, 41-cycle spacing.
    n_ack1 = 0; mode1 = 2; data1 = 8'h96; req1 = 1'b1;
    run(128);
    check("hold_ack1_count", n_ack1, 4);
    check("hold_ack1_spacing", t_ack1 - t_ack1_prev, 41);
    mode1 = 0; req1 = 1'b0;
    run(45);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 1500; i++) begin
      rst = ($urandom_range(299) == 0);
      if (!req0 && $urandom_range(7) == 0) begin data0 = 8'($urandom); req0 = 1'b1; end
      if (!req1 && $urandom_range(7) == 0) begin data1 = 8'($urandom); req1 = 1'b1; end
      tick();
    end
    rst = 1'b0; req0 = 1'b0; req1 = 1'b0;
    run(45);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
